// File: rtl/render_pkg.sv
// Shared constants for the rope-node renderer: coordinate width default,
// fixed colours and the 7-entry node palette used when NODE_PALETTE_EN is set.
package render_pkg;

   localparam int unsigned COORD_W_DEF = 10;

   localparam logic [2:0] FG_RGB_DEF = 3'b001;
   localparam logic [2:0] BG_RGB_DEF = 3'b111;
   localparam logic [2:0] BLACK_RGB  = 3'b000;

   // Entry k holds colour k+1, so index 0 maps to 3'b001.
   localparam logic [6:0][2:0] PALETTE = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};

   function automatic logic [2:0] palette_rgb(input int unsigned idx);
      logic [2:0] sel;
      sel = 3'(idx % 7);
      return PALETTE[sel];
   endfunction

endpackage

// File: rtl/node_renderer_if.sv
// Pixel/node bus between the rope simulator, sync stage and node_renderer.
// master drives positions and pixel stream, slave (the renderer) returns colour.
interface node_renderer_if #(
   parameter int unsigned NUM_NODES = 20,
   parameter int unsigned COORD_W   = 10,
   parameter int unsigned IDX_W     = $clog2(NUM_NODES)
);
   logic                           frame_start;
   logic [NUM_NODES*COORD_W-1:0]   nodes_x;
   logic [NUM_NODES*COORD_W-1:0]   nodes_y;
   logic                           video_on;
   logic [COORD_W-1:0]             pix_x;
   logic [COORD_W-1:0]             pix_y;
   logic [2:0]                     graph_rgb;
   logic                           hit;
   logic [IDX_W-1:0]               hit_idx;

   modport master (
      output frame_start, nodes_x, nodes_y, video_on, pix_x, pix_y,
      input  graph_rgb, hit, hit_idx
   );

   modport slave (
      input  frame_start, nodes_x, nodes_y, video_on, pix_x, pix_y,
      output graph_rgb, hit, hit_idx
   );
endinterface

// File: rtl/node_renderer_hit_pipe.sv
// node_hit_pipe: two-stage disc membership test for one node.
// Stage 1 registers signed centre-to-pixel distances, stage 2 the hit bit.
module node_hit_pipe #(
   parameter int unsigned COORD_W = 10,
   parameter int unsigned RADIUS  = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               snap_valid,
   input  logic [COORD_W-1:0] node_x,
   input  logic [COORD_W-1:0] node_y,
   input  logic [COORD_W-1:0] pix_x,
   input  logic [COORD_W-1:0] pix_y,
   output logic               hit_bit
);
   localparam int unsigned D_W  = COORD_W + 2;
   localparam int unsigned SQ_W = 2 * D_W + 1;

   logic [COORD_W:0]         cx, cy;
   logic signed [D_W-1:0]    dx_next, dy_next;
   logic signed [D_W-1:0]    dx_s1, dy_s1;
   logic                     valid_s1;
   logic signed [SQ_W-1:0]   dx_e, dy_e, sq;
   logic                     in_disc;

   // Disc centre and signed distance; the extra bits stop discs near 0 aliasing to the far edge.
   always_comb begin
      cx      = (COORD_W+1)'(node_x) + (COORD_W+1)'(RADIUS);
      cy      = (COORD_W+1)'(node_y) + (COORD_W+1)'(RADIUS);
      dx_next = $signed({1'b0, cx}) - $signed({2'b00, pix_x});
      dy_next = $signed({1'b0, cy}) - $signed({2'b00, pix_y});
   end

   // Stage 1 register; snap_valid travels with the pixel so in-flight pixels stay consistent.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dx_s1    <= '0;
         dy_s1    <= '0;
         valid_s1 <= 1'b0;
      end else begin
         dx_s1    <= dx_next;
         dy_s1    <= dy_next;
         valid_s1 <= snap_valid;
      end
   end

   // Squared distance against RADIUS squared.
   always_comb begin
      dx_e    = SQ_W'(dx_s1);
      dy_e    = SQ_W'(dy_s1);
      sq      = dx_e * dx_e + dy_e * dy_e;
      in_disc = (sq <= $signed(SQ_W'(RADIUS * RADIUS)));
   end

   // Stage 2 register: one bit of the hit vector.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) hit_bit <= 1'b0;
      else        hit_bit <= in_disc & valid_s1;
   end
endmodule

// File: rtl/node_renderer.sv
// node_renderer: per-pixel disc renderer for rope nodes, 3-cycle latency,
// one pixel per clock. Node positions are snapshotted on frame_start.
// Optional macro NODE_PALETTE_EN: colour discs from the palette by hit index
// instead of the single FG_RGB colour.
module node_renderer
   import render_pkg::*;
#(
   parameter int unsigned NUM_NODES = 20,
   parameter int unsigned COORD_W   = COORD_W_DEF,
   parameter int unsigned RADIUS    = 5,
   parameter logic [2:0]  FG_RGB    = FG_RGB_DEF,
   parameter logic [2:0]  BG_RGB    = BG_RGB_DEF,
   parameter int unsigned IDX_W     = $clog2(NUM_NODES)
) (
   input logic          clk,
   input logic          reset,
   node_renderer_if.slave bus
);
   logic [NUM_NODES*COORD_W-1:0] shadow_x, shadow_y;
   logic                         snap_valid;
   logic                         vo_s1, vo_s2;
   logic [NUM_NODES-1:0]         hitvec;
   logic                         any_hit;
   logic [IDX_W-1:0]             enc_idx;
   logic [2:0]                   disc_rgb;
   logic [2:0]                   rgb_q;
   logic                         hit_q;
   logic [IDX_W-1:0]             idx_q;

   // Position snapshot, only updated by frame_start.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow_x   <= '0;
         shadow_y   <= '0;
         snap_valid <= 1'b0;
      end else if (bus.frame_start) begin
         shadow_x   <= bus.nodes_x;
         shadow_y   <= bus.nodes_y;
         snap_valid <= 1'b1;
      end
   end

   // video_on delay matching the two hit-pipe stages.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vo_s1 <= 1'b0;
         vo_s2 <= 1'b0;
      end else begin
         vo_s1 <= bus.video_on;
         vo_s2 <= vo_s1;
      end
   end

   for (genvar i = 0; i < NUM_NODES; i++) begin : g_node
      node_hit_pipe #(
         .COORD_W (COORD_W),
         .RADIUS  (RADIUS)
      ) u_pipe (
         .clk        (clk),
         .reset      (reset),
         .snap_valid (snap_valid),
         .node_x     (shadow_x[i*COORD_W +: COORD_W]),
         .node_y     (shadow_y[i*COORD_W +: COORD_W]),
         .pix_x      (bus.pix_x),
         .pix_y      (bus.pix_y),
         .hit_bit    (hitvec[i])
      );
   end

   // Priority encoder: scan downwards so the lowest set index wins.
   always_comb begin
      any_hit = |hitvec;
      enc_idx = '0;
      for (int unsigned i = NUM_NODES; i > 0; i--) begin
         if (hitvec[i-1]) enc_idx = IDX_W'(i - 1);
      end
`ifdef NODE_PALETTE_EN
      disc_rgb = palette_rgb(32'(enc_idx));
`else
      disc_rgb = FG_RGB;
`endif
   end

   // Output register, blanked outside the visible area.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rgb_q <= BLACK_RGB;
         hit_q <= 1'b0;
         idx_q <= '0;
      end else begin
         rgb_q <= vo_s2 ? (any_hit ? disc_rgb : BG_RGB) : BLACK_RGB;
         hit_q <= vo_s2 & any_hit;
         idx_q <= (vo_s2 & any_hit) ? enc_idx : '0;
      end
   end

   assign bus.graph_rgb = rgb_q;
   assign bus.hit       = hit_q;
   assign bus.hit_idx   = idx_q;
endmodule

// File: doc/node_renderer.md
# node_renderer

Parametrised per-pixel renderer for rope nodes. It sits between the rope simulator and the VGA sync/output stage. Node positions are snapshotted at frame start so a frame never tears mid-scan. Each pixel is tested against NUM_NODES filled discs in a 3-stage pipeline, and the block emits the 3-bit pixel colour plus hit information.

## Interface
- NUM_NODES, 20, number of discs drawn.
- COORD_W, 10, width of every coordinate (pixel and node).
- RADIUS, 5, disc radius in pixels; the disc centre is node position + RADIUS on each axis.
- FG_RGB, 3'b001, disc colour when the palette is compiled out.
- BG_RGB, 3'b111, colour of visible pixels not covered by any disc.
- IDX_W, $clog2(NUM_NODES), width of hit_idx.
- clk  in  1  pixel clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- frame_start  in  1  one-cycle pulse at start of vertical blank; latches node positions.
- nodes_x  in  NUM_NODES*COORD_W  flat node x positions; node i at bits [i*COORD_W +: COORD_W].
- nodes_y  in  NUM_NODES*COORD_W  flat node y positions; same packing.
- video_on  in  1  current pixel is in the visible area.
- pix_x, pix_y  in  COORD_W each  current pixel coordinate.
- graph_rgb  out  3  pixel colour, registered.
- hit  out  1  pixel covered by at least one disc (video_on qualified).
- hit_idx  out  IDX_W  lowest index of a covering node; 0 when hit=0.

## Operation
- Snapshot: on a clk edge with frame_start=1, all nodes_x/nodes_y are copied into shadow registers and snap_valid is set.
  - Shadow registers are unchanged at all other times.
  - Only shadow values are used for rendering.
- Until the first frame_start after reset, snap_valid=0. In that state no hits occur and visible pixels show BG_RGB.
- Stage 1: compute cx = x_i + RADIUS and cy = y_i + RADIUS at COORD_W+1 bits unsigned (no wrap).
  - dx = cx − pix_x and dy = cy − pix_y, signed, COORD_W+2 bits.
  - Register dx/dy for all nodes, plus video_on.
- Stage 2: sq_i = dx² + dy² at 2*(COORD_W+2)+1 bits.
  - hitvec[i] = (sq_i ≤ RADIUS²) & snap_valid.
  - Register hitvec and video_on.
- Stage 3: a priority encoder picks the lowest set index.
  - graph_rgb = video_on ? (any hit ? disc colour : BG_RGB) : 3'b000.
  - hit = video_on & |hitvec.
  - hit_idx = the encoded index when hit=1, else 0.
- Discs are drawn with signed distances. A disc near x=0 or y=0 must not alias to the far edge of the screen.
- Overlapping discs: the lowest index wins, so node 0 is on top.
- frame_start in the same cycle as active pixels: the new snapshot affects pixels entering stage 1 on the next cycle. Pixels already in flight keep the old positions.

## Timing
- Latency is exactly 3 cycles from pix_x/pix_y/video_on to graph_rgb/hit/hit_idx. The sync stage must delay hsync/vsync by 3 cycles to match.
- Throughput is one pixel per clk with no stall.
- Reset values: graph_rgb=3'b000, hit=0, hit_idx=0, all shadow registers=0, snap_valid=0, all pipeline registers=0.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous). After release, output stays black/BG until the next frame_start.
- video_on=0 gives graph_rgb=000 and hit=0 regardless of hitvec.

## Configuration
- NODE_PALETTE_EN defined: disc colour = palette[hit_idx mod 7]. The palette is the 7 non-black 3-bit colours 001..111, in order, with index 0 mapping to 3'b001.
- NODE_PALETTE_EN undefined: every disc uses FG_RGB. This matches the current single-colour look.

## Structure
- Shared package render_pkg: COORD_W default, BG/FG colour constants, black constant, and the 7-entry palette constant.
- Sub-module node_hit_pipe: one instance per node via generate. It takes the shadow position and the pixel, and produces a registered hitvec bit after 2 cycles.
- Top-level node_renderer: snapshot registers, video_on delay line, priority encoder, and output register.

## Test plan
- Reset then pixels with no frame_start: node 0 at (100,100), pixel (105,105), video_on=1 → graph_rgb=111 and hit=0 on every cycle.
- frame_start with node 3 at (100,100): pixel (105,105) → 3 cycles later hit=1, hit_idx=3, graph_rgb=FG_RGB (001). Pixel (111,105) → hit=0, graph_rgb=111.
- Edge disc: node 0 at (0,0), pixel (1023,5) → hit=0 (no wrap alias). Pixel (0,5) → hit=1 (distance 5 = RADIUS).
- Overlap: nodes 2 and 7 both at (50,50), pixel (55,55) → hit_idx=2. With NODE_PALETTE_EN → graph_rgb=011.
- Snapshot isolation: change nodes_x mid-frame without frame_start → output unchanged. Pulse frame_start → pixels from the next cycle on use the new positions.
- Blanking and reset: video_on=0 over a disc → 000 and hit=0. Assert reset mid-stream → outputs 0 immediately, and snap_valid is cleared.
